updown_counter_cascade: RTL and testbench

//   Parametrised, cascadable sync-load up/down counter, MC10E136 style.

---
 rtl/updown_counter_cascade.sv | 109 ++++++++++
 tb/tb_updown_counter_cascade.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_cascade.sv
// Cascadable synchronous-load up/down counter with programmable modulus,
// wrap/saturate ends, registered terminal-count/lookahead flags and a carry chain.
module updown_counter_cascade #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             clout,
  output logic             cout,
  output logic             wrap,
  output logic             load_err
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_M1  = WIDTH'(MODULUS - 2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so the range check also works when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic             dir;  // 0 = up, 1 = down
  logic             nxt_dir;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_wrap;
  logic             nxt_lerr;
  logic             nxt_tc;
  logic             nxt_clout;

  always_comb begin
    nxt_dir  = dir;
    nxt_out  = out;
    nxt_wrap = 1'b0;
    nxt_lerr = 1'b0;
    case (mode_e'(mode))
      MODE_LOAD: begin
        if ({1'b0, preset} >= MOD_EXT) begin
          nxt_out  = TOP;
          nxt_lerr = 1'b1;
        end else begin
          nxt_out = preset;
        end
      end
      MODE_DOWN: begin
        nxt_dir = 1'b1;
        if (cin) begin
          if (out != '0) begin
            nxt_out = out - ONE;
          end else if (!SATURATE) begin
            nxt_out  = TOP;
            nxt_wrap = 1'b1;
          end
        end
      end
      MODE_UP: begin
        nxt_dir = 1'b0;
        if (cin) begin
          if (out != TOP) begin
            nxt_out = out + ONE;
          end else if (!SATURATE) begin
            nxt_out  = '0;
            nxt_wrap = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Flags describe the value being registered, so they line up with out.
  always_comb begin
    nxt_tc    = nxt_dir ? (nxt_out == '0)  : (nxt_out == TOP);
    nxt_clout = nxt_dir ? (nxt_out == ONE) : (nxt_out == TOP_M1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out      <= '0;
      dir      <= 1'b0;
      tc       <= 1'b0;
      clout    <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      out      <= nxt_out;
      dir      <= nxt_dir;
      tc       <= nxt_tc;
      clout    <= nxt_clout;
      wrap     <= nxt_wrap;
      load_err <= nxt_lerr;
    end
  end

  // Ripple carry to the next stage; combinational by design.
  assign cout = tc & cin;

endmodule

// File: tb/tb_updown_counter_cascade.sv
// Randomised + directed bench for updown_counter_cascade: wrap, saturate,
// full-width and a two-decade cascade, each checked against a behavioural model.
module tb_updown_counter_cascade;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       cin;
  logic [7:0] preset;
  logic       chk_en = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] d0_out, d1_out, lo_out, hi_out;
  logic [7:0] d2_out;
  logic d0_tc, d0_cl, d0_co, d0_w, d0_le;
  logic d1_tc, d1_cl, d1_co, d1_w, d1_le;
  logic d2_tc, d2_cl, d2_co, d2_w, d2_le;
  logic lo_tc, lo_cl, lo_co, lo_w, lo_le;
  logic hi_tc, hi_cl, hi_co, hi_w, hi_le;

  updown_counter_cascade #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cin(cin), .preset(preset[3:0]),
    .out(d0_out), .tc(d0_tc), .clout(d0_cl), .cout(d0_co), .wrap(d0_w), .load_err(d0_le));

  updown_counter_cascade #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cin(cin), .preset(preset[3:0]),
    .out(d1_out), .tc(d1_tc), .clout(d1_cl), .cout(d1_co), .wrap(d1_w), .load_err(d1_le));

  updown_counter_cascade u_d2 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cin(cin), .preset(preset),
    .out(d2_out), .tc(d2_tc), .clout(d2_cl), .cout(d2_co), .wrap(d2_w), .load_err(d2_le));

  updown_counter_cascade #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cin(cin), .preset(preset[3:0]),
    .out(lo_out), .tc(lo_tc), .clout(lo_cl), .cout(lo_co), .wrap(lo_w), .load_err(lo_le));

  updown_counter_cascade #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .reset_n(reset_n), .mode(mode), .cin(lo_co), .preset(preset[3:0]),
    .out(hi_out), .tc(hi_tc), .clout(hi_cl), .cout(hi_co), .wrap(hi_w), .load_err(hi_le));

  // ---------------- behavioural model ----------------
  typedef struct {
    int out;
    bit dir;  // 1 = counting down
    bit wrap;
    bit lerr;
  } st_t;

  st_t m0 = '{0, 1'b0, 1'b0, 1'b0};
  st_t m1 = '{0, 1'b0, 1'b0, 1'b0};
  st_t m2 = '{0, 1'b0, 1'b0, 1'b0};
  st_t ml = '{0, 1'b0, 1'b0, 1'b0};
  st_t mh = '{0, 1'b0, 1'b0, 1'b0};

  function automatic st_t step(st_t s, bit rn, int md, bit ci, int pre, int m, bit sat);
    st_t n;
    n = s;
    n.wrap = 1'b0;
    n.lerr = 1'b0;
    if (!rn) begin
      n.out = 0;
      n.dir = 1'b0;
      return n;
    end
    if (md == 1) n.dir = 1'b1;
    if (md == 2) n.dir = 1'b0;
    if (md == 0) begin
      if (pre < m) n.out = pre;
      else begin n.out = m - 1; n.lerr = 1'b1; end
    end else if (md == 2 && ci) begin
      if (s.out < m - 1) n.out = s.out + 1;
      else if (!sat) begin n.out = 0; n.wrap = 1'b1; end
    end else if (md == 1 && ci) begin
      if (s.out > 0) n.out = s.out - 1;
      else if (!sat) begin n.out = m - 1; n.wrap = 1'b1; end
    end
    return n;
  endfunction

  function automatic bit tc_of(st_t s, int m);
    return s.dir ? (s.out == 0) : (s.out == m - 1);
  endfunction

  function automatic bit cl_of(st_t s, int m);
    return s.dir ? (s.out == 1) : (s.out == m - 2);
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, reset_n, int'(mode), cin, int'(preset[3:0]), 10, 1'b0);
    m1 <= step(m1, reset_n, int'(mode), cin, int'(preset[3:0]), 10, 1'b1);
    m2 <= step(m2, reset_n, int'(mode), cin, int'(preset), 256, 1'b0);
    ml <= step(ml, reset_n, int'(mode), cin, int'(preset[3:0]), 10, 1'b0);
    mh <= step(mh, reset_n, int'(mode), tc_of(ml, 10) & cin, int'(preset[3:0]), 10, 1'b0);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_stage(input string nm, input st_t s, input int m, input bit ci,
                           input logic [7:0] o, input logic t, input logic cl,
                           input logic co, input logic w, input logic le);
    cmp({nm, ".out"},      32'(o),  32'(s.out));
    cmp({nm, ".tc"},       32'(t),  32'(tc_of(s, m)));
    cmp({nm, ".clout"},    32'(cl), 32'(cl_of(s, m)));
    cmp({nm, ".cout"},     32'(co), 32'(tc_of(s, m) & ci));
    cmp({nm, ".wrap"},     32'(w),  32'(s.wrap));
    cmp({nm, ".load_err"}, 32'(le), 32'(s.lerr));
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      cmp_stage("d0", m0, 10,  cin, {4'b0, d0_out}, d0_tc, d0_cl, d0_co, d0_w, d0_le);
      cmp_stage("d1", m1, 10,  cin, {4'b0, d1_out}, d1_tc, d1_cl, d1_co, d1_w, d1_le);
      cmp_stage("d2", m2, 256, cin, d2_out,         d2_tc, d2_cl, d2_co, d2_w, d2_le);
      cmp_stage("lo", ml, 10,  cin, {4'b0, lo_out}, lo_tc, lo_cl, lo_co, lo_w, lo_le);
      cmp_stage("hi", mh, 10,  tc_of(ml, 10) & cin,
                {4'b0, hi_out}, hi_tc, hi_cl, hi_co, hi_w, hi_le);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input int md, input bit ci, input int pre);
    @(negedge clk);
    reset_n = r;
    mode    = md[1:0];
    cin     = ci;
    preset  = pre[7:0];
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    mode    = 2'b11;
    cin     = 1'b0;
    preset  = '0;
    chk_en  = 1'b1;

    // reset from an unknown state
    cyc(0, 3, 1, 0);
    cmp("rst.out", 32'(d0_out), 0);
    cmp("rst.tc", 32'(d0_tc), 0);
    cmp("rst.clout", 32'(d0_cl), 0);
    cmp("rst.cout", 32'(d0_co), 0);
    cmp("rst.wrap", 32'(d0_w), 0);
    cmp("rst.load_err", 32'(d0_le), 0);

    // load 7, count up through the top
    cyc(1, 0, 0, 7);
    cmp("up.load", 32'(d0_out), 7);
    cyc(1, 2, 1, 0);
    cmp("up.8", 32'(d0_out), 8);
    cmp("up.8.clout", 32'(d0_cl), 1);
    cyc(1, 2, 1, 0);
    cmp("up.9", 32'(d0_out), 9);
    cmp("up.9.tc", 32'(d0_tc), 1);
    cmp("up.9.cout", 32'(d0_co), 1);
    cyc(1, 2, 1, 0);
    cmp("up.0", 32'(d0_out), 0);
    cmp("up.0.wrap", 32'(d0_w), 1);
    cmp("up.0.tc", 32'(d0_tc), 0);

    // load 3, count down through zero
    cyc(1, 0, 0, 3);
    cyc(1, 1, 1, 0);
    cmp("dn.2", 32'(d0_out), 2);
    cyc(1, 1, 1, 0);
    cmp("dn.1", 32'(d0_out), 1);
    cmp("dn.1.clout", 32'(d0_cl), 1);
    cyc(1, 1, 1, 0);
    cmp("dn.0", 32'(d0_out), 0);
    cmp("dn.0.tc", 32'(d0_tc), 1);
    cyc(1, 1, 1, 0);
    cmp("dn.9", 32'(d0_out), 9);
    cmp("dn.9.wrap", 32'(d0_w), 1);
    cmp("dn.9.tc", 32'(d0_tc), 0);

    // saturating stage held at the top
    cyc(1, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2, 1, 0);
      cmp("sat.out", 32'(d1_out), 9);
      cmp("sat.tc", 32'(d1_tc), 1);
      cmp("sat.wrap", 32'(d1_w), 0);
    end
    cyc(1, 1, 1, 0);
    cmp("sat.dn", 32'(d1_out), 8);
    cmp("sat.dn.tc", 32'(d1_tc), 0);
    cmp("sat.dn.clout", 32'(d1_cl), 0);

    // out-of-range load, then reset mid-count
    cyc(1, 0, 0, 12);
    cmp("lerr.out", 32'(d0_out), 9);
    cmp("lerr.pulse", 32'(d0_le), 1);
    cyc(1, 3, 1, 0);
    cmp("lerr.clear", 32'(d0_le), 0);
    cmp("lerr.hold", 32'(d0_out), 9);
    cyc(1, 2, 1, 0);
    cyc(1, 2, 1, 0);
    cmp("mid.1", 32'(d0_out), 1);
    cyc(0, 2, 1, 0);
    cmp("mid.rst", 32'(d0_out), 0);

    // two-decade cascade 00..99 -> 00
    cyc(0, 3, 0, 0);
    for (int i = 1; i <= 100; i++) begin
      cyc(1, 2, 1, 0);
      cmp("casc", 32'(int'(hi_out) * 10 + int'(lo_out)), 32'(i % 100));
      if (i == 99) begin
        cyc(1, 2, 0, 0);
        cmp("casc.stall", 32'(int'(hi_out) * 10 + int'(lo_out)), 99);
        cmp("casc.lo_cout", 32'(lo_co), 0);
        cmp("casc.hi_cout", 32'(hi_co), 0);
      end
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      int md;
      sel = int'($urandom_range(0, 9));
      md  = (sel == 0) ? 0 : (sel <= 4) ? 1 : (sel <= 8) ? 2 : 3;
      cyc($urandom_range(0, 59) != 0, md, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 255)));
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
